// File: rtl/frame_tx_1111001.sv
// rtl/frame_tx_1111001.sv - serial frame transmitter: 1111001 sync, MSB-first payload, idle gap
module frame_tx_1111001 #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              x,
    output logic              sync_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] DATA_PEN  = CW'((DATA_W > 1) ? DATA_W - 2 : 0);
    localparam logic [3:0]    GAP_LAST  = 4'((GAP > 0) ? GAP - 1 : 0);
    // Sync pattern 1111001 stored in emission order, bit 0 goes out first
    localparam logic [6:0]    SYNC_BITS = 7'b1001111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_GAP
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        sync_cnt, sync_cnt_nx;
    logic [CW-1:0]     data_cnt, data_cnt_nx;
    logic [3:0]        gap_cnt, gap_cnt_nx;
    logic [DATA_W-1:0] shift_q, shift_nx;
    logic              x_q, x_nx;
    logic              sync_q, sync_nx;
    logic              done_q, done_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sync_cnt <= '0;
            data_cnt <= '0;
            gap_cnt  <= '0;
            shift_q  <= '0;
            x_q      <= 1'b0;
            sync_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            sync_cnt <= sync_cnt_nx;
            data_cnt <= data_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            shift_q  <= shift_nx;
            x_q      <= x_nx;
            sync_q   <= sync_nx;
            done_q   <= done_nx;
        end
    end

    // The state names the field whose bit is on x this cycle, so x and the
    // flags are computed one transition ahead and registered with the state.
    always_comb begin
        state_nx    = state;
        sync_cnt_nx = sync_cnt;
        data_cnt_nx = data_cnt;
        gap_cnt_nx  = gap_cnt;
        shift_nx    = shift_q;
        x_nx        = 1'b0;
        sync_nx     = 1'b0;
        done_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_in) begin
                    shift_nx    = data_in;
                    sync_cnt_nx = 3'd0;
                    state_nx    = S_SYNC;
                    x_nx        = SYNC_BITS[0];
                    sync_nx     = 1'b1;
                end
            end
            S_SYNC: begin
                if (sync_cnt == 3'd6) begin
                    state_nx    = S_DATA;
                    data_cnt_nx = '0;
                    x_nx        = shift_q[DATA_W-1];
                    shift_nx    = shift_q << 1;
                    done_nx     = (DATA_W == 1);
                end else begin
                    sync_cnt_nx = sync_cnt + 3'd1;
                    x_nx        = SYNC_BITS[sync_cnt_nx];
                    sync_nx     = 1'b1;
                end
            end
            S_DATA: begin
                if (data_cnt == DATA_LAST) begin
                    state_nx   = (GAP > 0) ? S_GAP : S_IDLE;
                    gap_cnt_nx = 4'd0;
                end else begin
                    data_cnt_nx = data_cnt + CW'(1);
                    x_nx        = shift_q[DATA_W-1];
                    shift_nx    = shift_q << 1;
                    done_nx     = (data_cnt == DATA_PEN);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 4'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign x          = x_q;
    assign sync_out   = sync_q;
    assign frame_done = done_q;
    assign ready_out  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_frame_tx_1111001.sv
// tb/tb_frame_tx_1111001.sv - scoreboard bench for frame_tx_1111001 (GAP=2, GAP=0, GAP=1 instances)
module tb_frame_tx_1111001;

    typedef struct packed {
        logic x;
        logic sy;
        logic fd;
        logic rdy;
        logic bsy;
        logic z;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [7:0] din   [3];
    logic       vin   [3];
    logic       rdy_w [3];
    logic       x_w   [3];
    logic       so_w  [3];
    logic       bsy_w [3];
    logic       fd_w  [3];

    logic [6:0] hist;
    logic       zdet;
    logic [6:0] mh [3];
    rec_t       q [$];
    int         passed;
    int         total;
    int         zhits;

    frame_tx_1111001 #(.DATA_W(8), .GAP(2)) u0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(vin[0]), .ready_out(rdy_w[0]),
        .x(x_w[0]), .sync_out(so_w[0]), .busy(bsy_w[0]), .frame_done(fd_w[0])
    );
    frame_tx_1111001 #(.DATA_W(8), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(vin[1]), .ready_out(rdy_w[1]),
        .x(x_w[1]), .sync_out(so_w[1]), .busy(bsy_w[1]), .frame_done(fd_w[1])
    );
    frame_tx_1111001 #(.DATA_W(8), .GAP(1)) u2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid_in(vin[2]), .ready_out(rdy_w[2]),
        .x(x_w[2]), .sync_out(so_w[2]), .busy(bsy_w[2]), .frame_done(fd_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping Moore 1111001 detector listening to the GAP=1 line
    always_ff @(posedge clk) begin
        if (rst) hist <= 7'd0;
        else     hist <= {hist[5:0], x_w[2]};
    end
    assign zdet = (hist == 7'b1111001);

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) mh[k] = {mh[k][5:0], 1'b0};
        end
    endtask

    // Offers nfr words on instance idx starting at the next edge and checks every
    // cycle through the trailing IDLE cycle of the last frame.
    task automatic send(input int idx, input int gap, input int nfr,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3, input bit noise);
        logic [7:0] w [4];
        logic [6:0] sp;
        logic [7:0] cur;
        rec_t       e;
        rec_t       g;
        int         period;
        int         p;
        int         f;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        sp = 7'b1111001;
        period = 16 + gap;
        for (int fr = 0; fr < nfr; fr++) begin
            cur = w[fr];
            for (int c = 1; c <= period; c++) begin
                if (c <= 7)       e.x = sp[7 - c];
                else if (c <= 15) e.x = cur[15 - c];
                else              e.x = 1'b0;
                e.sy  = (c <= 7);
                e.fd  = (c == 15);
                e.rdy = (c == period);
                e.bsy = (c != period);
                e.z   = (idx == 2) ? (mh[idx] == 7'b1111001) : 1'b0;
                mh[idx] = {mh[idx][5:0], e.x};
                q.push_back(e);
            end
        end
        din[idx] = w[0];
        vin[idx] = 1'b1;
        @(posedge clk);
        for (int t = 0; t < nfr * period; t++) begin
            @(negedge clk);
            p = t % period + 1;
            f = t / period;
            if (q.size() == 0) begin
                total++;
                $display("FAIL scoreboard_empty inst%0d cyc%0d: got empty queue, want record", idx, p);
            end else begin
                e = q.pop_front();
                g = '{x: x_w[idx], sy: so_w[idx], fd: fd_w[idx], rdy: rdy_w[idx],
                      bsy: bsy_w[idx], z: (idx == 2) ? zdet : 1'b0};
                if (idx == 2 && zdet) zhits++;
                total++;
                if (g !== e)
                    $display("FAIL frame inst%0d frm%0d cyc%0d: got x/sync/fd/rdy/busy/z=%b, want %b",
                             idx, f, p, g, e);
                else
                    passed++;
            end
            if (noise && p < 15) begin
                din[idx] = 8'($urandom);
                vin[idx] = 1'($urandom_range(0, 1));
            end else if (p >= 15) begin
                if (f + 1 < nfr) begin
                    din[idx] = w[f + 1];
                    vin[idx] = 1'b1;
                end else begin
                    vin[idx] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[k] = 8'h00;
            vin[k] = 1'b0;
            mh[k]  = 7'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({x_w[k], so_w[k], fd_w[k], rdy_w[k], bsy_w[k]} !== 5'b00010)
                $display("FAIL reset inst%0d: got x/sync/fd/rdy/busy=%b, want 00010", k,
                         {x_w[k], so_w[k], fd_w[k], rdy_w[k], bsy_w[k]});
            else
                passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        send(0, 2, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        send(1, 0, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_loopback;
        zhits = 0;
        send(2, 1, 4, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0);
        total++;
        if (zhits !== 4) $display("FAIL loopback_hits: got %0d, want 4", zhits);
        else passed++;
    endtask

    task automatic test_embedded;
        zhits = 0;
        send(2, 1, 1, 8'h79, 8'h00, 8'h00, 8'h00, 1'b0);
        total++;
        if (zhits !== 2) $display("FAIL embedded_hits: got %0d, want 2", zhits);
        else passed++;
    endtask

    task automatic test_busy_ignore;
        send(0, 2, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [6:0] sp;
        logic [7:0] d;
        logic       ex;
        sp = 7'b1111001;
        d  = 8'hA5;
        din[0] = d;
        vin[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            vin[0] = 1'b0;
            ex = (c <= 7) ? sp[7 - c] : d[15 - c];
            total++;
            if (x_w[0] !== ex) $display("FAIL partial_frame cyc%0d: got x=%b, want %b", c, x_w[0], ex);
            else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({x_w[0], so_w[0], fd_w[0], rdy_w[0], bsy_w[0]} !== 5'b00010)
            $display("FAIL reset_mid: got x/sync/fd/rdy/busy=%b, want 00010",
                     {x_w[0], so_w[0], fd_w[0], rdy_w[0], bsy_w[0]});
        else
            passed++;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) mh[k] = 7'd0;
        send(0, 2, 1, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        zhits  = 0;
        rst    = 1'b1;
        test_reset;
        idle_cycles(2);
        test_single;
        idle_cycles(3);
        test_back_to_back;
        idle_cycles(3);
        test_loopback;
        idle_cycles(3);
        test_embedded;
        idle_cycles(3);
        test_busy_ignore;
        idle_cycles(3);
        test_reset_mid;
        idle_cycles(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
